// File: rtl/counter_pkg.sv
// Shared encodings for the modulo counter: mode and direction codes.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // The unused 2'b11 encoding behaves as wrap.
  function automatic logic is_wrap_mode(input logic [1:0] mode);
    return (mode == MODE_WRAP) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Clock-enable prescaler: asserts step once every psc+1 enabled cycles.
module step_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [PSC_W-1:0] psc,
  output logic             step
);

  logic [PSC_W-1:0] psc_cnt;

  // Exact compare against the live psc: if psc shrinks below psc_cnt, the
  // counter runs on to all-ones and wraps before it matches again.
  assign step = en && (psc_cnt == psc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (sync_clr || step) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= psc_cnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap/saturate/one-shot modes, prescaled
// stepping and a registered terminal-count pulse.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PSC_W-1:0] psc,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             wrap_mode;

  // A finished one-shot freezes the prescaler as well as the count.
  step_prescaler #(.PSC_W(PSC_W)) u_step_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en & ~done_q),
    .sync_clr (clr | load),
    .psc      (psc),
    .step     (step)
  );

  assign wrap_mode = is_wrap_mode(mode);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (step) begin
      case (dir)
        DIR_UP: begin
          if (count_q >= limit) begin
            if (wrap_mode) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = limit;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
            tc_d    = !wrap_mode && (count_d == limit);
          end
        end
        DIR_DN: begin
          if (count_q == '0) begin
            if (wrap_mode) begin
              count_d = limit;
              tc_d    = 1'b1;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
            tc_d    = !wrap_mode && (count_q == WIDTH'(1));
          end
        end
      endcase
      if (tc_d && (mode == MODE_ONESHOT)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed scenarios plus random stimulus
// against a behavioural model of the counting rules.
module tb_mod_counter;

  localparam int WIDTH = 8;
  localparam int PSC_W = 4;
  localparam int CMAX  = 1 << WIDTH;
  localparam int PMAX  = 1 << PSC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1;
  logic [WIDTH-1:0] load_val = '0, limit = '0;
  logic [1:0]       mode = 2'b00;
  logic [PSC_W-1:0] psc = '0;
  logic [WIDTH-1:0] count;
  logic             tc, done;

  mod_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode), .limit(limit), .psc(psc),
    .count(count), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int tc;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Behavioural model state
  int m_cnt = 0, m_pc = 0, m_done = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Apply the sampled inputs of the coming edge to the model.
  task automatic model_edge(output exp_t e);
    int ev = 0;
    int md = (mode == 2'b11) ? 0 : int'(mode);
    int lim = int'(limit);
    if (clr) begin
      m_cnt = 0; m_pc = 0; m_done = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_pc = 0; m_done = 0;
    end else if (en && m_done == 0) begin
      if (m_pc == int'(psc)) begin
        m_pc = 0;
        if (dir) begin
          if (m_cnt >= lim) begin
            if (md == 0) begin m_cnt = 0; ev = 1; end
            else m_cnt = lim;
          end else begin
            m_cnt = m_cnt + 1;
            if (md != 0 && m_cnt == lim) ev = 1;
          end
        end else begin
          if (m_cnt == 0) begin
            if (md == 0) begin m_cnt = lim; ev = 1; end
          end else begin
            m_cnt = m_cnt - 1;
            if (md != 0 && m_cnt == 0) ev = 1;
          end
        end
        if (ev == 1 && md == 2) m_done = 1;
      end else begin
        m_pc = (m_pc + 1) % PMAX;
      end
    end
    e.count = m_cnt % CMAX;
    e.tc    = ev;
    e.done  = m_done;
  endtask

  // Called at a falling edge with inputs already set for the next rising edge.
  task automatic tick();
    exp_t e;
    model_edge(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset mid-cycle, outputs checked before any clock edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_count", int'(count), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_done", int'(done), 0);
    m_cnt = 0; m_pc = 0; m_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every rising edge presents a new output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.count);
        check("tc", int'(tc), e.tc);
        check("done", int'(done), e.done);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Wrap up, limit 5
    en = 1; clr = 0; load = 0; dir = 1; mode = 2'b00; limit = 8'd5; psc = '0;
    ticks(14);

    // Prescale by 4, with an enable gap
    clr = 1; tick(); clr = 0;
    psc = 4'd3; limit = 8'd255;
    ticks(32);
    en = 0; ticks(2); en = 1;
    ticks(10);

    // Saturate down from 3
    psc = '0; mode = 2'b01; dir = 0;
    load = 1; load_val = 8'd3; tick(); load = 0;
    ticks(6);

    // One-shot up to 4, frozen, then reloaded
    mode = 2'b10; dir = 1; limit = 8'd4;
    clr = 1; tick(); clr = 0;
    ticks(16);
    load = 1; load_val = 8'd2; tick(); load = 0;
    ticks(5);

    // Priority, then above-limit load in wrap mode
    mode = 2'b00; limit = 8'd10;
    load = 1; load_val = 8'd7; tick();
    clr = 1; tick(); clr = 0;
    load_val = 8'd200; tick(); load = 0;
    ticks(3);

    // limit 0 wrap keeps tc high; reset cuts it off
    limit = '0; ticks(3);
    do_reset();
    limit = 8'd20; psc = 4'd2; ticks(3);
    do_reset();
    ticks(10);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      clr      = (r < 2);
      load     = (r >= 2 && r < 6);
      load_val = WIDTH'($urandom_range(0, CMAX - 1));
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0)
        limit = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 15))
                                            : WIDTH'($urandom_range(0, CMAX - 1));
      if ($urandom_range(0, 99) == 0)
        psc = ($urandom_range(0, 1) != 0) ? PSC_W'($urandom_range(0, 3))
                                          : PSC_W'($urandom_range(0, PMAX - 1));
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    clr = 0; load = 0; en = 0;
    ticks(2);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down counter for the Tiny Tapeout counter designs, generalising the fixed 8-bit up-counter. It adds:

- configurable width,
- a programmable modulo limit,
- direction control,
- wrap, saturate and one-shot modes,
- a clock-enable prescaler,
- a registered terminal-count pulse.

It sits beneath the `tt_um_*` top, which maps `ui_in`/`uio_in` onto its controls and handles pad output-enable gating.

## Interface
Parameters:
- `WIDTH`, 8, counter width in bits (2..16)
- `PSC_W`, 4, prescaler ratio field width (1..8)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: count enable (top gates it with `ena`)
- `clr` in 1: synchronous clear
- `load` in 1: synchronous load of `load_val`
- `load_val` in WIDTH: load data
- `dir` in 1: 1 = up, 0 = down
- `mode` in 2: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- `limit` in WIDTH: top value; count range 0..limit
- `psc` in PSC_W: one step per `psc+1` enabled cycles
- `count` out WIDTH: current count
- `tc` out 1: terminal-count pulse, registered
- `done` out 1: one-shot finished; counting halted

## Operation
- Priority per edge: `clr` > `load` > step. `clr` and `load` both zero the prescaler and clear `done`.
  - `clr`: count←0.
  - `load`: count←`load_val`; may exceed `limit`.
- Prescaler: `psc_cnt` increments on each cycle with `en`=1 and `done`=0.
  - A *step* occurs in a cycle with `en`=1, `done`=0 and `psc_cnt`==`psc`; `psc_cnt`←0 at that edge.
  - With `en`=0, `psc_cnt` holds.
  - `psc`=0 gives one step per enabled cycle.
  - `psc` changing mid-count: the compare uses the new value. If `psc_cnt` > new `psc`, `psc_cnt` continues up to all-ones, wraps to 0, then matches.
- Step, up (`dir`=1):
  - Boundary is count ≥ `limit`; otherwise count+1.
  - At boundary, wrap mode: count←0, terminal event.
  - At boundary, saturate mode: count←`limit`, no event.
  - Arrival at boundary: a step from count+1==`limit` is a terminal event in saturate and one-shot modes.
  - One-shot: `done`←1 on the arrival event; stepping stops.
- Step, down (`dir`=0):
  - Boundary is count==0; otherwise count−1.
  - At boundary, wrap mode: count←`limit`, event.
  - At boundary, saturate mode: hold 0.
  - Arrival at 0: a step from 1 is an event in saturate and one-shot modes.
- Count above `limit`, down: ordinary decrement.
- `limit`=0:
  - Wrap: every step is an event and count stays 0.
  - Saturate and one-shot: no arrival is possible from 0, hence no event.
- Changing `dir` or `mode` takes effect on the next step. No state is reset.
- All arithmetic is mod 2^WIDTH. No intermediate wider than WIDTH+1.

## Timing
- Reset (async assert, sync deassert handled upstream): count=0, `psc_cnt`=0, `tc`=0, `done`=0.
- `count` updates at the edge where the step, load or clear is sampled; it is visible the next cycle.
- `tc` is high for exactly one cycle, the cycle after the edge that performed the terminal event. It is never high on a `clr`/`load` edge.
- `done` rises in the same cycle `tc` rises and stays high until `clr`, `load` or reset.
- Reset mid-count clears immediately. `tc` drops without completing its pulse.
- No combinational path from any input to any output.

## Structure
- Package `counter_pkg`: localparams `MODE_WRAP`=2'b00, `MODE_SAT`=2'b01, `MODE_ONESHOT`=2'b10; `dir` constants `DIR_UP`/`DIR_DN`.
- Sub-module `step_prescaler` (`PSC_W`; ports `clk`, `rst_n`, `en`, `sync_clr`, `psc`, `step`): owns `psc_cnt`. `step` is combinational.
- `mod_counter` holds the count, `done` and `tc` registers plus next-state logic.

## Test plan
- Wrap up, WIDTH=8, `limit`=5, `psc`=0, `en`=1: count 0,1,2,3,4,5,0. `tc` high only in the cycle after the 5→0 edge.
- Prescale, `psc`=3, `limit`=255: count increments once every 4 cycles. 8 steps take 32 cycles. Toggling `en` low for 2 cycles delays the next step by 2.
- Saturate down from `load_val`=3: count 3,2,1,0,0. `tc` pulses once after the 1→0 edge, never while holding.
- One-shot up, `limit`=4: count reaches 4, then `tc`=1 and `done`=1. Count frozen for 10 cycles. `load_val`=2 clears `done` and counting resumes.
- Priority: `clr`=1 and `load`=1 on the same edge with count=7 gives count=0. Loading 200 with `limit`=10 in wrap mode, up: the next step gives 0 and `tc`.
- Async reset: assert `rst_n`=0 mid-step with `psc_cnt`=2 and `tc`=1. All outputs are 0 immediately. After release, the first step occurs `psc`+1 cycles later.
